gmii_rx_framer: RTL and testbench

GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

---
 rtl/gmii_rx_framer_pkg.sv | 23 ++
 rtl/gmii_rx_framer_if.sv | 14 +
 rtl/eth_crc32_d8.sv | 21 ++
 rtl/gmii_rx_framer.sv | 195 +++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gmii_rx_framer_pkg.sv
// Shared Ethernet receive constants and the framer state type.
package gmii_rx_framer_pkg;

    localparam logic [7:0]  ETH_PRE       = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    // Bit-reversed form of 0x04C11DB7, used by the LSB-first shifter.
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    // Preamble counter saturation value.
    localparam logic [2:0]  PRE_CNT_MAX   = 3'd7;
    // Four bytes in the FCS delay line plus one in the pending register.
    localparam logic [2:0]  FILL_FULL     = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/gmii_rx_framer_if.sv
// Byte stream leaving the framer: no back-pressure, the sink always accepts.
// A byte transfers in every cycle where tvalid is high; tlast marks the final
// byte of a frame and tuser (meaningful only with tlast) flags a bad frame.
interface gmii_rx_framer_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);

endinterface

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32.
module eth_crc32_d8
    import gmii_rx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Eight LSB-first shift steps with the data byte folded in up front.
    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks and strips the FCS and
// emits frame bytes with end-of-frame and bad-frame marking.
module gmii_rx_framer
    import gmii_rx_framer_pkg::*;
#(
    parameter int unsigned PREAMBLE_MIN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    gmii_rx_framer_if.master m_axis,
    output logic             stat_start_packet,
    output logic             stat_frame_good,
    output logic             stat_frame_bad,
    output rx_state_t        dbg_state
);

    localparam logic [2:0] PRE_MIN = 3'(PREAMBLE_MIN);

    logic [7:0]      rxd_q;
    logic            dv_q;
    logic            er_q;
    rx_state_t       state, state_next;
    logic [2:0]      pre_cnt, pre_cnt_next;
    logic [3:0][7:0] dly;
    logic [7:0]      pend;
    logic [2:0]      fill;
    logic [31:0]     crc, crc_next;
    logic            err_seen;
    logic            take_byte, frame_start, frame_end, pend_full;
    logic [7:0]      out_data, out_data_n;
    logic            out_valid, out_valid_n, out_last, out_last_n, out_user, out_user_n;
    logic            good_n, bad_n;

    // Register the PHY inputs. dv resets to 1 with a 0x00 byte so the first
    // decode after reset sees a busy line and parks in DROP until the line
    // goes idle, discarding any frame already in flight at release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_q <= '0;
            dv_q  <= 1'b1;
            er_q  <= 1'b0;
        end else begin
            rxd_q <= gmii_rxd;
            dv_q  <= gmii_rx_dv;
            er_q  <= gmii_rx_er;
        end
    end

    // FSM state and preamble counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pre_cnt <= '0;
        end else begin
            state   <= state_next;
            pre_cnt <= pre_cnt_next;
        end
    end

    // Next-state decode on the registered GMII byte.
    always_comb begin
        state_next   = state;
        pre_cnt_next = pre_cnt;
        take_byte    = 1'b0;
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dv_q) begin
                    if (rxd_q == ETH_PRE) begin
                        state_next   = ST_PREAMBLE;
                        pre_cnt_next = 3'd1;
                    end else if (rxd_q == ETH_SFD && PRE_MIN == 3'd0) begin
                        state_next  = ST_PAYLOAD;
                        frame_start = 1'b1;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!dv_q) begin
                    state_next = ST_IDLE;
                end else if (er_q) begin
                    state_next = ST_DROP;
                end else if (rxd_q == ETH_PRE) begin
                    if (pre_cnt != PRE_CNT_MAX) pre_cnt_next = pre_cnt + 3'd1;
                end else if (rxd_q == ETH_SFD && pre_cnt >= PRE_MIN) begin
                    state_next  = ST_PAYLOAD;
                    frame_start = 1'b1;
                end else begin
                    state_next = ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                if (dv_q) begin
                    take_byte = 1'b1;
                end else begin
                    frame_end  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!dv_q) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (rxd_q),
        .crc_out (crc_next)
    );

    // FCS delay line, pending byte, CRC accumulator and error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly      <= '0;
            pend     <= '0;
            fill     <= '0;
            crc      <= CRC_INIT;
            err_seen <= 1'b0;
        end else if (frame_start) begin
            fill     <= '0;
            crc      <= CRC_INIT;
            err_seen <= 1'b0;
        end else if (take_byte) begin
            dly <= {dly[2:0], rxd_q};
            if (fill >= 3'd4) pend <= dly[3];
            if (fill != FILL_FULL) fill <= fill + 3'd1;
            crc <= crc_next;
            if (er_q) err_seen <= 1'b1;
        end
    end

    assign pend_full = (fill == FILL_FULL);

    // Emit the pending byte when a newer byte pushes it out, or as the
    // tlast byte when the frame ends; frames too short to fill the pending
    // register only report a bad-frame pulse.
    always_comb begin
        out_valid_n = 1'b0;
        out_last_n  = 1'b0;
        out_user_n  = 1'b0;
        good_n      = 1'b0;
        bad_n       = 1'b0;
        if (take_byte && pend_full) begin
            out_valid_n = 1'b1;
        end
        if (frame_end) begin
            if (pend_full) begin
                out_valid_n = 1'b1;
                out_last_n  = 1'b1;
                out_user_n  = err_seen || (crc != CRC_RESIDUE);
                good_n      = !out_user_n;
                bad_n       = out_user_n;
            end else begin
                bad_n = 1'b1;
            end
        end
        out_data_n = out_valid_n ? pend : 8'h00;
    end

    // Output and status register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data          <= '0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            out_user          <= 1'b0;
            stat_start_packet <= 1'b0;
            stat_frame_good   <= 1'b0;
            stat_frame_bad    <= 1'b0;
        end else begin
            out_data          <= out_data_n;
            out_valid         <= out_valid_n;
            out_last          <= out_last_n;
            out_user          <= out_user_n;
            stat_start_packet <= frame_start;
            stat_frame_good   <= good_n;
            stat_frame_bad    <= bad_n;
        end
    end

    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign m_axis.tuser  = out_user;
    assign dbg_state     = state;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: frame table plus hand sequences for
// preamble errors, short frames and mid-frame reset.
module tb_gmii_rx_framer;
    import gmii_rx_framer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       stat_start_packet;
    logic       stat_frame_good;
    logic       stat_frame_bad;
    rx_state_t  dbg_state;

    gmii_rx_framer_if m_axis_if ();

    gmii_rx_framer #(.PREAMBLE_MIN(1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .gmii_rxd          (gmii_rxd),
        .gmii_rx_dv        (gmii_rx_dv),
        .gmii_rx_er        (gmii_rx_er),
        .m_axis            (m_axis_if),
        .stat_start_packet (stat_start_packet),
        .stat_frame_good   (stat_frame_good),
        .stat_frame_bad    (stat_frame_bad),
        .dbg_state         (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fr_q[$];

    // Output monitor: records every byte and event with its cycle number.
    logic [7:0] got_mem [0:4095];
    int   got_wr = 0;
    int   rd = 0;
    int   mon_last_cnt = 0, mon_good = 0, mon_bad = 0, mon_start = 0, mon_viol = 0;
    int   mon_first_cyc = 0, mon_last_cyc = 0, mon_bad_cyc = 0;
    logic mon_user = 1'b0;
    logic mid = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) mid = 1'b0;
        if (m_axis_if.tvalid) begin
            got_mem[got_wr] = m_axis_if.tdata;
            got_wr++;
            if (!mid) mon_first_cyc = cyc;
            mid = !m_axis_if.tlast;
            if (m_axis_if.tlast) begin
                mon_last_cnt++;
                mon_last_cyc = cyc;
                mon_user     = m_axis_if.tuser;
            end
        end else if (m_axis_if.tlast || m_axis_if.tuser || stat_frame_good) begin
            mon_viol++;
        end
        if (stat_frame_good) mon_good++;
        if (stat_frame_bad) begin
            mon_bad++;
            mon_bad_cyc = cyc;
        end
        if (stat_start_packet) mon_start++;
    end

    typedef struct {
        int   n_pre;
        int   pay_len;
        int   flip_at;
        int   er_at;
        int   exp_bytes;
        logic exp_user;
        int   exp_good;
        int   exp_bad;
        int   exp_start;
    } vec_t;

    vec_t vecs[7];

    int s_got, s_last, s_good, s_bad, s_start, s_viol;
    int n_cyc, e_cyc, rel_got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // Driver tasks
    task automatic drive_byte(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk);
        #1;
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_byte(8'h00, 1'b0, 1'b0);
    endtask

    // Payload followed by its FCS (complemented CRC, least significant byte first).
    task automatic build_frame(input int pay_len, input int flip_at, input int seed);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        fr_q.delete();
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < pay_len; i++) begin
            b = 8'(seed + i * 13 + i / 5);
            fr_q.push_back(b);
            c = crc_byte(c, b);
        end
        fcs = ~c;
        fr_q.push_back(fcs[7:0]);
        fr_q.push_back(fcs[15:8]);
        fr_q.push_back(fcs[23:16]);
        fr_q.push_back(fcs[31:24]);
        if (flip_at >= 0) fr_q[flip_at] = fr_q[flip_at] ^ 8'h10;
    endtask

    task automatic send_built(input int n_pre, input int er_at, output int n_c, output int e_c);
        n_c = 0;
        for (int i = 0; i < n_pre; i++) drive_byte(8'h55, 1'b1, 1'b0);
        drive_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < fr_q.size(); i++) begin
            drive_byte(fr_q[i], 1'b1, i == er_at);
            if (i == 0) n_c = cyc;
        end
        drive_byte(8'h00, 1'b0, 1'b0);
        e_c = cyc;
    endtask

    task automatic snap();
        s_got   = got_wr;
        s_last  = mon_last_cnt;
        s_good  = mon_good;
        s_bad   = mon_bad;
        s_start = mon_start;
        s_viol  = mon_viol;
    endtask

    // Scoreboard: compare one frame's outputs against the expected queue.
    task automatic check_frame(input string nm, input int exp_bytes, input logic exp_user,
                               input int exp_good, input int exp_bad, input int exp_start,
                               input int n_c, input int e_c);
        logic [7:0] eb;
        int idx;
        check($sformatf("%s.bytes", nm), 32'(got_wr - s_got), 32'(exp_bytes));
        check($sformatf("%s.tlast_cnt", nm), 32'(mon_last_cnt - s_last), (exp_bytes > 0) ? 32'd1 : 32'd0);
        check($sformatf("%s.good", nm), 32'(mon_good - s_good), 32'(exp_good));
        check($sformatf("%s.bad", nm), 32'(mon_bad - s_bad), 32'(exp_bad));
        check($sformatf("%s.start", nm), 32'(mon_start - s_start), 32'(exp_start));
        check($sformatf("%s.idle_flags", nm), 32'(mon_viol - s_viol), 32'd0);
        if (exp_bytes > 0) begin
            check($sformatf("%s.first_cyc", nm), 32'(mon_first_cyc), 32'(n_c + 7));
            check($sformatf("%s.last_cyc", nm), 32'(mon_last_cyc), 32'(e_c + 2));
            check($sformatf("%s.tuser", nm), 32'(mon_user), 32'(exp_user));
        end else if (exp_bad > 0) begin
            check($sformatf("%s.bad_cyc", nm), 32'(mon_bad_cyc), 32'(e_c + 2));
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            if (rd < got_wr) begin
                check($sformatf("%s.byte%0d", nm, idx), 32'(got_mem[rd]), 32'(eb));
                rd++;
            end else begin
                total++;
                bad++;
                $display("FAIL %s.byte%0d: no output byte, expected %0h", nm, idx, eb);
            end
            idx++;
        end
        rd = got_wr;
    endtask

    initial begin
        vecs[0] = '{7, 60, -1, -1, 60, 1'b0, 1, 0, 1};  // clean 60-byte frame
        vecs[1] = '{7, 60,  5, -1, 60, 1'b1, 0, 1, 1};  // payload bit flip
        vecs[2] = '{7, 60, -1, 10, 60, 1'b1, 0, 1, 1};  // rx_er on payload byte 10
        vecs[3] = '{1,  1, -1, -1,  1, 1'b0, 1, 0, 1};  // 5 bytes after SFD, minimum preamble
        vecs[4] = '{2, 46, 48, -1, 46, 1'b1, 0, 1, 1};  // corrupted FCS byte
        vecs[5] = '{3,  1, -1,  2,  1, 1'b1, 0, 1, 1};  // rx_er inside FCS
        vecs[6] = '{0, 10, -1, -1,  0, 1'b0, 0, 0, 0};  // SFD without preamble

        // Reset block
        rst_n      = 1'b0;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.tvalid", 32'(m_axis_if.tvalid), 32'd0);
        check("rst.tlast", 32'(m_axis_if.tlast), 32'd0);
        check("rst.tuser", 32'(m_axis_if.tuser), 32'd0);
        check("rst.start", 32'(stat_start_packet), 32'd0);
        check("rst.good", 32'(stat_frame_good), 32'd0);
        check("rst.bad", 32'(stat_frame_bad), 32'd0);
        check("rst.state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            build_frame(vecs[v].pay_len, vecs[v].flip_at, v * 31 + 7);
            for (int i = 0; i < vecs[v].exp_bytes; i++) exp_q.push_back(fr_q[i]);
            snap();
            send_built(vecs[v].n_pre, vecs[v].er_at, n_cyc, e_cyc);
            idle(12);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_bytes, vecs[v].exp_user,
                        vecs[v].exp_good, vecs[v].exp_bad, vecs[v].exp_start, n_cyc, e_cyc);
        end

        // Broken preamble, one idle cycle, then a good frame
        snap();
        drive_byte(8'h55, 1'b1, 1'b0);
        drive_byte(8'h55, 1'b1, 1'b0);
        drive_byte(8'h5D, 1'b1, 1'b0);
        drive_byte(8'h55, 1'b1, 1'b0);
        drive_byte(8'hD5, 1'b1, 1'b0);
        @(negedge clk);
        check("badpre.state", 32'(dbg_state), 32'(ST_DROP));
        drive_byte(8'h11, 1'b1, 1'b0);
        drive_byte(8'h22, 1'b1, 1'b0);
        drive_byte(8'h33, 1'b1, 1'b0);
        drive_byte(8'h00, 1'b0, 1'b0);
        build_frame(20, -1, 91);
        for (int i = 0; i < 20; i++) exp_q.push_back(fr_q[i]);
        send_built(7, -1, n_cyc, e_cyc);
        idle(12);
        check_frame("badpre", 20, 1'b0, 1, 0, 1, n_cyc, e_cyc);

        // Frames shorter than five bytes after SFD
        for (int nb = 3; nb <= 4; nb++) begin
            snap();
            for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b1, 1'b0);
            drive_byte(8'hD5, 1'b1, 1'b0);
            for (int i = 0; i < nb; i++) drive_byte(8'(i + 1), 1'b1, 1'b0);
            drive_byte(8'h00, 1'b0, 1'b0);
            e_cyc = cyc;
            idle(12);
            check_frame($sformatf("short%0d", nb), 0, 1'b0, 0, 1, 1, 0, e_cyc);
        end

        // Reset pulsed during payload byte 20, released with dv still high
        snap();
        build_frame(60, -1, 200);
        rel_got = 0;
        for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b1, 1'b0);
        drive_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < fr_q.size(); i++) begin
            drive_byte(fr_q[i], 1'b1, 1'b0);
            if (i == 20) rst_n = 1'b0;
            if (i == 22) rst_n = 1'b1;
            if (i == 24) rel_got = got_wr;
        end
        drive_byte(8'h00, 1'b0, 1'b0);
        idle(12);
        check("rstmid.pre_bytes", 32'(rel_got - s_got), 32'd14);
        check("rstmid.post_bytes", 32'(got_wr - rel_got), 32'd0);
        check("rstmid.tlast_cnt", 32'(mon_last_cnt - s_last), 32'd0);
        check("rstmid.good", 32'(mon_good - s_good), 32'd0);
        check("rstmid.bad", 32'(mon_bad - s_bad), 32'd0);
        rd = got_wr;

        build_frame(30, -1, 77);
        for (int i = 0; i < 30; i++) exp_q.push_back(fr_q[i]);
        snap();
        send_built(7, -1, n_cyc, e_cyc);
        idle(12);
        check_frame("after_rst", 30, 1'b0, 1, 0, 1, n_cyc, e_cyc);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
